// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for an in-order MIPS pipeline. Every
// instruction leaving Decode declares when it needs its operands (tuse) and
// when its result becomes forwardable (tnew). A per-stage scoreboard follows
// each in-flight destination through stages 1..DEPTH (1 = E, 2 = M, 3 = W).
// It counts tnew down and produces the stall signal and the forward selects
// for the D and E stages. A latency counter models the occupancy of the
// multi-cycle multiply/divide unit (XALU).
//
// Parameters:
//   NREG     architectural register count (AW = $clog2(NREG))
//   DEPTH    number of tracked stages after Decode
//   MUL_LAT  mult/multu occupancy in cycles
//   DIV_LAT  div/divu occupancy in cycles
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   asynchronous, active-low, clears all state
//   d_valid        in   Decode holds a real instruction
//   d_rs, d_rt     in   source register numbers
//   d_rs_tuse,
//   d_rt_tuse      in   operand need time: 0 = D, 1 = E, 2 = M, 3 = unused
//   d_dst          in   destination register, 0 = none
//   d_tnew         in   cycles after entering E until the result is forwardable
//   d_xalu_start   in   mult/div instruction
//   d_xalu_div     in   with d_xalu_start, selects DIV_LAT
//   d_xalu_use     in   mfhi/mflo/mthi/mtlo
//   stall          out  freeze PC and F/D, bubble into E
//   fwd_rs_d,
//   fwd_rt_d       out  D-stage select: 0 = register file, k = stage k
//   fwd_rs_e,
//   fwd_rt_e       out  E-stage select: 0 = registered value, k in 2..DEPTH
//   xalu_busy      out  XALU occupancy counter non-zero
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int DEPTH   = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int AW     = $clog2(NREG),
  localparam int FW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [1:0]    d_rs_tuse,
  input  logic [1:0]    d_rt_tuse,
  input  logic [AW-1:0] d_dst,
  input  logic [1:0]    d_tnew,
  input  logic          d_xalu_start,
  input  logic          d_xalu_div,
  input  logic          d_xalu_use,
  output logic          stall,
  output logic [FW-1:0] fwd_rs_d,
  output logic [FW-1:0] fwd_rt_d,
  output logic [FW-1:0] fwd_rs_e,
  output logic [FW-1:0] fwd_rt_e,
  output logic          xalu_busy
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Result of a scoreboard lookup: whether any stage matched, which stage is
  // the youngest match, and the remaining tnew of that entry.
  typedef struct packed {
    logic          hit;
    logic [FW-1:0] stage;
    logic [1:0]    tnew;
  } match_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH:1]             valid_q, valid_d;
  logic [DEPTH:1][AW-1:0]     dst_q,   dst_d;
  logic [DEPTH:1][1:0]        tnew_q,  tnew_d;

  // Source operands of the instruction currently in E, used for E-stage
  // forwarding once the instruction has left Decode.
  logic [AW-1:0]              e_rs_q, e_rs_d;
  logic [AW-1:0]              e_rt_q, e_rt_d;
  logic [1:0]                 e_rs_tuse_q, e_rs_tuse_d;
  logic [1:0]                 e_rt_tuse_q, e_rt_tuse_d;

  logic [CW-1:0]              xcnt_q, xcnt_d;

  // ---------------------------------------------------------------------------
  // Youngest-match search. Walking from the oldest stage to the youngest lets
  // the last hit win, which is the youngest one. Register 0 never matches.
  // ---------------------------------------------------------------------------
  function automatic match_t find_match(
    input logic [AW-1:0]         src,
    input int                    first,
    input logic [DEPTH:1]        v,
    input logic [DEPTH:1][AW-1:0] d,
    input logic [DEPTH:1][1:0]   t
  );
    match_t m;
    m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if ((k >= first) && v[k] && (d[k] == src) && (src != '0)) begin
        m.hit   = 1'b1;
        m.stage = FW'(k);
        m.tnew  = t[k];
      end
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection and D-stage forwarding
  // ---------------------------------------------------------------------------
  match_t m_rs_d, m_rt_d, m_rs_e, m_rt_e;
  logic   rs_haz, rt_haz, xalu_haz;
  logic   issue;

  always_comb begin
    m_rs_d = find_match(d_rs, 1, valid_q, dst_q, tnew_q);
    m_rt_d = find_match(d_rt, 1, valid_q, dst_q, tnew_q);

    // A source stalls only if it is really used and the producer's result
    // arrives later than the cycle the operand is needed.
    rs_haz   = m_rs_d.hit && (d_rs_tuse != TUSE_NONE) && (m_rs_d.tnew > d_rs_tuse);
    rt_haz   = m_rt_d.hit && (d_rt_tuse != TUSE_NONE) && (m_rt_d.tnew > d_rt_tuse);
    xalu_haz = (d_xalu_start | d_xalu_use) & xalu_busy;

    stall = d_valid & (rs_haz | rt_haz | xalu_haz);
    issue = d_valid & ~stall;

    // D-side selects ignore tuse: the datapath may pick up a ready value
    // early even when the operand is consumed later.
    fwd_rs_d = (m_rs_d.hit && (m_rs_d.tnew == 2'd0)) ? m_rs_d.stage : '0;
    fwd_rt_d = (m_rt_d.hit && (m_rt_d.tnew == 2'd0)) ? m_rt_d.stage : '0;
  end

  // ---------------------------------------------------------------------------
  // E-stage forwarding. Stage 1 is the E instruction itself, so the search
  // starts at stage 2.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_rs_e = find_match(e_rs_q, 2, valid_q, dst_q, tnew_q);
    m_rt_e = find_match(e_rt_q, 2, valid_q, dst_q, tnew_q);

    fwd_rs_e = (m_rs_e.hit && (m_rs_e.tnew == 2'd0) && (e_rs_tuse_q != TUSE_NONE))
               ? m_rs_e.stage : '0;
    fwd_rt_e = (m_rt_e.hit && (m_rt_e.tnew == 2'd0) && (e_rt_tuse_q != TUSE_NONE))
               ? m_rt_e.stage : '0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift. Stage 1 takes the issuing instruction (a bubble when
  // stalled); each later stage takes its predecessor with tnew counted down.
  // ---------------------------------------------------------------------------
  assign valid_d[1] = issue & (d_dst != '0);
  assign dst_d[1]   = d_dst;
  assign tnew_d[1]  = d_tnew;

  for (genvar gi = 2; gi <= DEPTH; gi++) begin : g_shift
    assign valid_d[gi] = valid_q[gi-1];
    assign dst_d[gi]   = dst_q[gi-1];
    assign tnew_d[gi]  = (tnew_q[gi-1] == 2'd0) ? 2'd0 : (tnew_q[gi-1] - 2'd1);
  end

  // E-side operand tracking moves in lockstep with stage 1.
  always_comb begin
    e_rs_d      = issue ? d_rs      : '0;
    e_rt_d      = issue ? d_rt      : '0;
    e_rs_tuse_d = issue ? d_rs_tuse : 2'd0;
    e_rt_tuse_d = issue ? d_rt_tuse : 2'd0;
  end

  // ---------------------------------------------------------------------------
  // XALU occupancy counter. Loaded as the start instruction enters E, so the
  // count covers the instruction's own E cycle; otherwise counts down to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    xcnt_d = xcnt_q;
    if (issue && d_xalu_start) begin
      xcnt_d = d_xalu_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (xcnt_q != '0) begin
      xcnt_d = xcnt_q - CW'(1);
    end
  end

  assign xalu_busy = (xcnt_q != '0);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      dst_q       <= '0;
      tnew_q      <= '0;
      e_rs_q      <= '0;
      e_rt_q      <= '0;
      e_rs_tuse_q <= '0;
      e_rt_tuse_q <= '0;
      xcnt_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      dst_q       <= dst_d;
      tnew_q      <= tnew_d;
      e_rs_q      <= e_rs_d;
      e_rt_q      <= e_rt_d;
      e_rs_tuse_q <= e_rs_tuse_d;
      e_rt_tuse_q <= e_rt_tuse_d;
      xcnt_q      <= xcnt_d;
    end
  end

endmodule
